gate_response_checker: RTL and testbench
========================================

// Module: gate_response_checker
// PURPOSE
//   Self-checking response side for combinational gate tests (NAND etc.).
//   Sequences every input vector of an N_IN-input gate under test, waits a settle
//   time, samples the gate output and compares it with a truth-table parameter.
//   Reports the per-vector mismatch mask, the error count and pass/done.
//   Sits beside the gate under test in on-chip and board-level gate checks.
// PARAMETERS
//   N_IN      2         number of gate inputs (1..4)
//   EXPECTED  4'b0111   golden truth table, bit i = expected out for stim==i (NAND)
//   SETTLE    4         cycles stim is held before sampling (>=1)
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous, active-high reset
//   start      in   1           begin a run; sampled in IDLE or DONE only
//   dut_out    in   1           output of gate under test
//   stim       out  N_IN        gate inputs, stim[1]=in1, stim[0]=in2 for N_IN=2
//   busy       out  1           run in progress
//   done       out  1           run finished; held until next start or reset
//   pass       out  1           done && err_count==0
//   fail_mask  out  2**N_IN     bit i set = vector i mismatched
//   err_count  out  N_IN+1      number of mismatched vectors
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; stim, busy, done, pass, fail_mask,
//     err_count, settle counter all 0.
//   - States: IDLE, SETTLE, SAMPLE, DONE.
//   - IDLE/DONE + start=1 at edge: fail_mask=0, err_count=0, done=0, pass=0,
//     stim=0, cnt=0, busy=1 -> SETTLE.
//   - SETTLE: cnt increments each cycle; after SETTLE cycles in SETTLE -> SAMPLE.
//   - SAMPLE (one cycle): at its closing edge dut_out compared with EXPECTED[stim];
//     mismatch sets fail_mask[stim], err_count+1.
//     stim != 2**N_IN-1: stim+1, cnt=0 -> SETTLE.
//     stim == 2**N_IN-1: stim=0, busy=0, done=1, pass=(final err_count==0) -> DONE.
//   - Per vector SETTLE+1 cycles; done rises 2**N_IN*(SETTLE+1) edges after the
//     start edge (20 edges at defaults). Results update in the same edge as compare.
//   - start while busy: ignored, no restart, no result change.
//   - start held high continuously: after DONE a new run begins on the next edge
//     (done high exactly one cycle in that case).
//   - stim changes only at the SAMPLE->SETTLE edge; stable throughout SETTLE+SAMPLE.
//   - dut_out X/Z at sample: counted as mismatch (compare uses !==).
//   - err_count never wraps: max value 2**N_IN fits N_IN+1 bits.
//   - Reset mid-run: immediate abort, all outputs to reset values, next start
//     begins a clean run from stim=0.
// TESTING
//   1 Golden NAND on stim, start pulse -> stim walks 0,1,2,3 each held 5 cycles;
//     done=1 at edge 20; pass=1, fail_mask=4'b0000, err_count=0.
//   2 DUT forced stuck-at-1 -> fail_mask=4'b1000, err_count=1, pass=0, done=1.
//   3 DUT = AND gate -> fail_mask=4'b1111, err_count=4, pass=0.
//   4 Extra start pulses at edges 3 and 12 of a run -> ignored; done still at edge
//     20, results identical to test 1.
//   5 rst asserted while stim=2 -> same cycle busy=0, stim=0, fail_mask=0;
//     start after release -> full clean run, pass=1 with golden NAND.
//   6 Run with stuck-at-0 (fail_mask=4'b0111), then start from DONE with golden
//     NAND -> results cleared at start edge, final pass=1, fail_mask=0.

Source files
------------

// File: rtl/gate_response_checker.sv
// Response-side checker for combinational gate tests. Walks every input
// vector of an N_IN-input gate, holds each one for SETTLE cycles, samples the
// gate output for one cycle and compares it against the golden truth table.
module gate_response_checker #(
  parameter int unsigned        N_IN     = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 4'b0111,
  parameter int unsigned        SETTLE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   fail_mask,
  output logic [N_IN:0]        err_count
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  STIM_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [N_IN-1:0]       stim_q,      stim_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  pass_q,      pass_d;
  logic [2**N_IN-1:0]    fail_mask_q, fail_mask_d;
  logic [N_IN:0]         err_count_q, err_count_d;
  logic                  mismatch;

  // State and result registers; asynchronous reset aborts any run at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state and result update: sequence vectors, compare in SAMPLE.
  always_comb begin
    // NOTE: every signal driven here gets a hold-value default first, so no
    // branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;
    // Case-inequality so an X or Z from the gate counts as a failure in
    // simulation; synthesis treats it as an ordinary inequality.
    mismatch    = (dut_out !== EXPECTED[stim_q]);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          fail_mask_d = '0;
          err_count_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          stim_d      = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          fail_mask_d[stim_q] = 1'b1;
          err_count_d         = err_count_q + (N_IN + 1)'(1);
        end
        if (stim_q == STIM_LAST) begin
          stim_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
          state_d = S_DONE;
        end else begin
          stim_d  = stim_q + N_IN'(1);
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker at default parameters (2-input NAND,
// SETTLE=4). A behavioural gate model drives dut_out from stim; expected run
// results are queued when a run starts and popped when done rises.
module tb_gate_response_checker;

  typedef enum int {M_NAND, M_STUCK1, M_AND, M_STUCK0, M_ZVEC2} mode_e;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] err;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_out;
  logic [1:0] stim;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;

  mode_e mode = M_NAND;
  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  gate_response_checker dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_out   (dut_out),
    .stim      (stim),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic gate_model(mode_e m, logic [1:0] s);
    case (m)
      M_NAND:   return ~(s[1] & s[0]);
      M_STUCK1: return 1'b1;
      M_AND:    return s[1] & s[0];
      M_STUCK0: return 1'b0;
      M_ZVEC2:  return (s == 2'd2) ? 1'bz : ~(s[1] & s[0]);
      default:  return 1'bx;
    endcase
  endfunction

  assign dut_out = gate_model(mode, stim);

  // Expected results against a 2-input NAND truth table, per gate behaviour.
  function automatic exp_t expected_for(mode_e m);
    exp_t e;
    case (m)
      M_NAND:   begin e.mask = 4'b0000; e.err = 3'd0; end
      M_STUCK1: begin e.mask = 4'b1000; e.err = 3'd1; end
      M_AND:    begin e.mask = 4'b1111; e.err = 3'd4; end
      M_STUCK0: begin e.mask = 4'b0111; e.err = 3'd3; end
      default:  begin e.mask = 4'b0100; e.err = 3'd1; end
    endcase
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  // One complete run: start pulse, cycle-by-cycle stim/busy/done, final results.
  task automatic run_full(input mode_e m, input bit extra_starts, input string tag);
    exp_t e;
    mode = m;
    sb.push_back(expected_for(m));
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_checks++;
    if ({busy, done, pass, fail_mask, err_count, stim} !== {1'b1, 1'b0, 1'b0, 4'b0, 3'b0, 2'b0}) begin
      n_fail++;
      $display("FAIL %s start_clear: busy=%b done=%b pass=%b mask=%b err=%0d stim=%0d, want 1 0 0 0000 0 0",
               tag, busy, done, pass, fail_mask, err_count, stim);
    end
    for (int k = 1; k <= 20; k++) begin
      start = extra_starts && (k == 3 || k == 12);
      @(posedge clk); #1 start = 1'b0;
      n_checks++;
      if ({busy, done, stim} !== {(k < 20), (k == 20), (k < 20) ? 2'(k / 5) : 2'd0}) begin
        n_fail++;
        $display("FAIL %s edge%0d: busy=%b done=%b stim=%0d, want busy=%b done=%b stim=%0d",
                 tag, k, busy, done, stim, k < 20, k == 20, (k < 20) ? k / 5 : 0);
      end
    end
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({fail_mask, err_count, pass} !== {e.mask, e.err, e.pass}) begin
        n_fail++;
        $display("FAIL %s result: mask=%b err=%0d pass=%b, want mask=%b err=%0d pass=%b",
                 tag, fail_mask, err_count, pass, e.mask, e.err, e.pass);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({done, busy, fail_mask, err_count, pass} !== {1'b1, 1'b0, e.mask, e.err, e.pass}) begin
        n_fail++;
        $display("FAIL %s hold: done=%b busy=%b mask=%b err=%0d pass=%b, want 1 0 %b %0d %b",
                 tag, done, busy, fail_mask, err_count, pass, e.mask, e.err, e.pass);
      end
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s done_timeout: done=%b queued=%0d, want done=1 at edge 20", tag, done, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, pass, fail_mask, err_count, stim} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b pass=%b mask=%b err=%0d stim=%0d, want all 0",
               busy, done, pass, fail_mask, err_count, stim);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, stim} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b done=%b stim=%0d, want 0 0 0", busy, done, stim);
    end
  endtask

  task automatic test_golden();      run_full(M_NAND,   1'b0, "golden");      endtask
  task automatic test_stuck1();      run_full(M_STUCK1, 1'b0, "stuck1");      endtask
  task automatic test_and_gate();    run_full(M_AND,    1'b0, "and_gate");    endtask
  task automatic test_extra_start(); run_full(M_NAND,   1'b1, "extra_start"); endtask
  task automatic test_xz_sample();   run_full(M_ZVEC2,  1'b0, "z_sample");    endtask

  task automatic test_reset_mid_run();
    bit found = 1'b0;
    mode = M_STUCK0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk); #1;
      found = (stim === 2'd2);
    end
    n_checks++;
    if (!found || fail_mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL midrun_reach: found_stim2=%b mask=%b, want 1 0011", found, fail_mask);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, pass, fail_mask, err_count, stim} !== 11'b0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: busy=%b done=%b pass=%b mask=%b err=%0d stim=%0d, want all 0",
               busy, done, pass, fail_mask, err_count, stim);
    end
    @(negedge clk) rst = 1'b0;
    run_full(M_NAND, 1'b0, "after_reset");
  endtask

  task automatic test_rerun_from_done();
    run_full(M_STUCK0, 1'b0, "rerun_first");
    run_full(M_NAND,   1'b0, "rerun_second");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    mode = M_STUCK1;
    sb.push_back(expected_for(M_STUCK1));
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      if (k == 20) begin
        e = sb.pop_front();
        n_checks++;
        if ({done, busy, fail_mask, err_count, pass} !== {1'b1, 1'b0, e.mask, e.err, e.pass}) begin
          n_fail++;
          $display("FAIL b2b_done: done=%b busy=%b mask=%b err=%0d pass=%b, want 1 0 %b %0d %b",
                   done, busy, fail_mask, err_count, pass, e.mask, e.err, e.pass);
        end
      end else if (k == 21) begin
        n_checks++;
        if ({done, busy, fail_mask, err_count, stim} !== {1'b0, 1'b1, 4'b0, 3'b0, 2'b0}) begin
          n_fail++;
          $display("FAIL b2b_restart: done=%b busy=%b mask=%b err=%0d stim=%0d, want 0 1 0000 0 0",
                   done, busy, fail_mask, err_count, stim);
        end
      end
    end
    start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want bench to finish first");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_golden();
    test_stuck1();
    test_and_gate();
    test_extra_start();
    test_reset_mid_run();
    test_rerun_from_done();
    test_xz_sample();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
